// File: rtl/hazard_pkg.sv
// hazard_pkg: scoreboard entry type, forward-select codes and MDU latencies for hazard_scoreboard
package hazard_pkg;
  localparam int SB_AW = 5;
  localparam int SB_TW = 4;
  typedef struct packed {
    logic [SB_AW-1:0] wa;
    logic             we;
    logic [SB_TW-1:0] tnew;
  } sb_entry_t;
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_W   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_E   = 2'd3;
  localparam logic [SB_TW-1:0] TUSE_NONE   = 4'd5;
  localparam logic [SB_TW-1:0] MULT_CYCLES = 4'd5;
  localparam logic [SB_TW-1:0] DIV_CYCLES  = 4'd10;
  function automatic logic [SB_TW-1:0] sat_dec(input logic [SB_TW-1:0] x);
    return x == '0 ? '0 : x - 1'b1;
  endfunction
endpackage

// File: rtl/hazard_md_counter.sv
// hazard_md_counter: MDU busy countdown, loaded on an accepted mult/div start
module hazard_md_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_div,
  output logic [SB_TW-1:0] o_cnt
);
  logic [SB_TW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= i_load ? (i_div ? DIV_CYCLES : MULT_CYCLES) : sat_dec(r_cnt);
  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W Tnew scoreboard producing D-stage stall and forward selects.
// Define HAZARD_MDU_EN to add MDU busy tracking (D_Md_Start/D_Md_Div/D_Md_Use).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = SB_AW,
  parameter int T_W    = SB_TW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] D_A1,
  input  logic [REG_AW-1:0] D_A2,
  input  logic              D_A1use,
  input  logic              D_A2use,
  input  logic [T_W-1:0]    D_rs_Tuse,
  input  logic [T_W-1:0]    D_rt_Tuse,
  input  logic [REG_AW-1:0] D_WA,
  input  logic              D_Reg_Write,
  input  logic [T_W-1:0]    D_Tnew,
`ifdef HAZARD_MDU_EN
  input  logic              D_Md_Start,
  input  logic              D_Md_Div,
  input  logic              D_Md_Use,
`endif
  output logic              Stall,
  output logic [1:0]        D_rs_Fwd,
  output logic [1:0]        D_rt_Fwd,
  output logic [T_W-1:0]    E_Tnew_o,
  output logic [T_W-1:0]    M_Tnew_o
);
  sb_entry_t r_e, r_m, r_w;
  logic w_stall_rs, w_stall_rt, w_md_stall;

  function automatic logic hit(input sb_entry_t s, input logic [REG_AW-1:0] a);
    return s.we && s.wa != '0 && s.wa == a;
  endfunction

  // Only the youngest live match decides; a ready E entry shadows a busy M entry.
  function automatic logic stall_op(input logic u, input logic [REG_AW-1:0] a,
                                    input logic [T_W-1:0] tuse, input sb_entry_t e, input sb_entry_t m);
    return u && a != '0 && (hit(e, a) ? tuse < e.tnew : hit(m, a) && tuse < m.tnew);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] a, input sb_entry_t e,
                                         input sb_entry_t m, input sb_entry_t w);
    return a == '0                       ? FWD_GRF :
           (hit(e, a) && e.tnew == '0)   ? FWD_E   :
           (hit(m, a) && m.tnew == '0)   ? FWD_M   :
           (hit(w, a) && w.tnew == '0)   ? FWD_W   : FWD_GRF;
  endfunction

`ifdef HAZARD_MDU_EN
  logic [SB_TW-1:0] w_md_cnt;
  hazard_md_counter u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (D_Md_Start && !Stall),
    .i_div  (D_Md_Div),
    .o_cnt  (w_md_cnt)
  );
  assign w_md_stall = D_Md_Use && w_md_cnt != '0;
`else
  assign w_md_stall = 1'b0;
`endif

  assign w_stall_rs = stall_op(D_A1use, D_A1, D_rs_Tuse, r_e, r_m);
  assign w_stall_rt = stall_op(D_A2use, D_A2, D_rt_Tuse, r_e, r_m);
  assign Stall      = w_stall_rs || w_stall_rt || w_md_stall;
  assign D_rs_Fwd   = fwd_sel(D_A1, r_e, r_m, r_w);
  assign D_rt_Fwd   = fwd_sel(D_A2, r_e, r_m, r_w);
  assign E_Tnew_o   = r_e.tnew;
  assign M_Tnew_o   = r_m.tnew;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= Stall ? '0 : sb_entry_t'{D_WA, D_Reg_Write, sat_dec(D_Tnew)};
      r_m <= sb_entry_t'{r_e.wa, r_e.we, sat_dec(r_e.tnew)};
      r_w <= sb_entry_t'{r_m.wa, r_m.we, sat_dec(r_m.tnew)};
    end
endmodule
